// File: rtl/ram8_8_arb.sv
// ram8_8_arb: two-client round-robin arbiter that serializes read/write requests onto a single-port 8x8 RAM
module ram8_8_arb #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_ram_wr,
  output logic              o_ram_rd,
  output logic [ADDR_W-1:0] o_ram_add,
  output logic [DATA_W-1:0] o_ram_data_in,
  input  logic [DATA_W-1:0] i_ram_data_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;
  state_t              r_state, w_next;
  logic                r_ptr, r_win, r_we;
  logic                r_gnt0, r_gnt1, r_ack0, r_ack1, r_ram_wr, r_ram_rd;
  logic [ADDR_W-1:0]   r_ram_add;
  logic [DATA_W-1:0]   r_ram_data_in, r_rdata0, r_rdata1;
  logic                w_any, w_win, w_sel_we, w_issue, w_done;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_gnt0, w_gnt1, w_ack0, w_ack1, w_wr, w_rd;
  logic [ADDR_W-1:0]   w_add;
  logic [DATA_W-1:0]   w_din, w_rdata0, w_rdata1;
  assign w_any       = i_req0 | i_req1;
  assign w_win       = (i_req0 & i_req1) ? r_ptr : i_req1;
  assign w_sel_we    = w_win ? i_we1 : i_we0;
  assign w_sel_addr  = w_win ? i_addr1 : i_addr0;
  assign w_sel_wdata = w_win ? i_wdata1 : i_wdata0;
  assign w_issue     = (r_state == IDLE) & w_any;
  assign w_done      = ((r_state == ISSUE) & r_we) | (r_state == RDWAIT);
  // state register, winner latch and round-robin pointer (pointer moves to the loser once the command is issued)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_issue) begin
        r_win <= w_win;
        r_we  <= w_sel_we;
      end
      if (r_state == ISSUE) r_ptr <= ~r_win;
    end
  end
  // next state: writes finish straight after ISSUE, reads wait one cycle for the RAM's registered output
  always_comb begin
    w_next = (r_state == IDLE)  ? (w_any ? ISSUE : IDLE) :
             (r_state == ISSUE) ? (r_we ? IDLE : RDWAIT) : IDLE;
  end
  // next values of the registered outputs
  always_comb begin
    w_gnt0   = w_issue & ~w_win;
    w_gnt1   = w_issue & w_win;
    w_wr     = w_issue & w_sel_we;
    w_rd     = w_issue & ~w_sel_we;
    w_ack0   = w_done & ~r_win;
    w_ack1   = w_done & r_win;
    w_add    = w_issue ? w_sel_addr : r_ram_add;
    w_din    = w_issue ? w_sel_wdata : r_ram_data_in;
    w_rdata0 = ((r_state == RDWAIT) & ~r_win) ? i_ram_data_out : r_rdata0;
    w_rdata1 = ((r_state == RDWAIT) & r_win) ? i_ram_data_out : r_rdata1;
  end
  // output registers; reset drops any in-flight strobe immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_ack0        <= 1'b0;
      r_ack1        <= 1'b0;
      r_ram_wr      <= 1'b0;
      r_ram_rd      <= 1'b0;
      r_ram_add     <= '0;
      r_ram_data_in <= '0;
      r_rdata0      <= '0;
      r_rdata1      <= '0;
    end else begin
      r_gnt0        <= w_gnt0;
      r_gnt1        <= w_gnt1;
      r_ack0        <= w_ack0;
      r_ack1        <= w_ack1;
      r_ram_wr      <= w_wr;
      r_ram_rd      <= w_rd;
      r_ram_add     <= w_add;
      r_ram_data_in <= w_din;
      r_rdata0      <= w_rdata0;
      r_rdata1      <= w_rdata1;
    end
  end
  assign o_gnt0        = r_gnt0;
  assign o_gnt1        = r_gnt1;
  assign o_ack0        = r_ack0;
  assign o_ack1        = r_ack1;
  assign o_ram_wr      = r_ram_wr;
  assign o_ram_rd      = r_ram_rd;
  assign o_ram_add     = r_ram_add;
  assign o_ram_data_in = r_ram_data_in;
  assign o_rdata0      = r_rdata0;
  assign o_rdata1      = r_rdata1;
endmodule

// File: doc/ram8_8_arb.md
# ram8_8_arb

Two-requester round-robin arbiter and access sequencer for the single-port `ram8_8` (8 x 8-bit, shared `wr`/`rd`/`add` port). It accepts independent read/write requests from two clients and serializes them onto the RAM one at a time. It owns the RAM's `wr`, `rd`, `add` and `data_in` pins. Read data comes back to the winning client with an acknowledge pulse.

## Interface
- `ADDR_W`, 3, RAM address width
- `DATA_W`, 8, RAM data width

- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req0`, `req1`  in  1  client request, held until matching `gnt` seen
- `we0`, `we1`  in  1  1 = write, 0 = read; valid with `req`
- `addr0`, `addr1`  in  ADDR_W  target address; valid with `req`
- `wdata0`, `wdata1`  in  DATA_W  write data; valid with `req`
- `gnt0`, `gnt1`  out  1  one-cycle pulse: command accepted; client may drop `req`
- `ack0`, `ack1`  out  1  one-cycle pulse: write committed / read data valid
- `rdata0`, `rdata1`  out  DATA_W  read data; holds last value until next read by that client
- `ram_wr`  out  1  to `ram8_8.wr`
- `ram_rd`  out  1  to `ram8_8.rd`
- `ram_add`  out  ADDR_W  to `ram8_8.add`
- `ram_data_in`  out  DATA_W  to `ram8_8.data_in`
- `ram_data_out`  in  DATA_W  from `ram8_8.data_out`; registered, valid the cycle after a `rd` edge

## Operation
- FSM states: IDLE, ISSUE, RDWAIT. All outputs are registered.
- In IDLE with no request, the FSM stays in IDLE. All strobes are 0.
- In IDLE with any `req` high:
  - Select the winner. If exactly one client requests, it wins.
  - If both request, the client named by priority pointer `ptr` wins.
  - Latch the winner's `we`, `addr` and `wdata`. Go to ISSUE.
- In ISSUE:
  - `gnt<w>` = 1.
  - `ram_add` and `ram_data_in` carry the latched values.
  - Exactly one of `ram_wr`/`ram_rd` = 1, according to the latched `we`.
  - On leaving ISSUE, `ptr` is set to the non-winner.
  - Write: next state IDLE, with `ack<w>` = 1 in the following cycle.
  - Read: next state RDWAIT.
- In RDWAIT:
  - `ram_wr` = `ram_rd` = 0.
  - At the edge, capture `ram_data_out` into `rdata<w>`, pulse `ack<w>`, go to IDLE.
- `ram_wr`, `ram_rd`, `gnt*` and `ack*` are 0 outside the cycles stated above. `ram_add` and `ram_data_in` hold their last values.
- Only one transaction is in flight at a time. The non-winning request stays pending and wins at the next IDLE decision.
- A client must not change `we`/`addr`/`wdata` while `req` is high and ungranted. `req` still high in the IDLE cycle after its `gnt` counts as a new request.

## Timing
- Reset values:
  - FSM = IDLE, `ptr` = 0 (client 0 favoured first).
  - `gnt*` = 0, `ack*` = 0, `rdata*` = 0.
  - `ram_wr` = 0, `ram_rd` = 0, `ram_add` = 0, `ram_data_in` = 0.
- Write: request sampled at edge E0 → ISSUE cycle (gnt, `ram_wr`) → RAM writes at E1 → `ack` high in the cycle after E1. Two cycles per write.
- Read: E0 sample → ISSUE (`ram_rd`) → RAM registers data at E1 → `rdata`/`ack` updated at E2. Three cycles per read.
- `ack` and updated `rdata` appear in the same cycle.
- Back-to-back throughput with both clients requesting: the grants strictly alternate 0,1,0,1.
- Reset mid-operation:
  - `rst_n` low clears all state immediately, including `ram_wr`/`ram_rd`.
  - The in-flight transaction is dropped with no `ack`. A write is committed only if its E1 edge preceded reset.
  - RAM contents are not cleared.
- Address and pointer arithmetic wraps naturally. The full address range 0..7 is legal.

## Test plan
- Reset: hold `rst_n`=0 with `req0`=`req1`=1 → all outputs 0. After release, the first grant goes to client 0.
- Single write/read: client 0 writes 8'd7 @0, then reads @0.
  - Write: `gnt0` in the cycle after request, `ack0` one cycle later.
  - Read: `ack0` at E2 with `rdata0`=8'd7. `rdata1` stays 0.
- Contention: both request simultaneously from IDLE — client 0 writes 8'd2 @6, client 1 writes 8'd3 @5.
  - Grants ordered 0 then 1.
  - Subsequent reads give `rdata1`=8'd2 @6 and `rdata0`=8'd3 @5.
- Fairness: both clients hold `req` high continuously for 8 reads.
  - Grants alternate.
  - Each client receives exactly 4 `ack`s.
  - `ram_wr`/`ram_rd` are never both high.
- Read of an unwritten address @4 after reset → `ack` with `rdata` equal to the RAM's power-on content (X in simulation). The checker accepts only the correct `ack` timing.
- Reset during ISSUE of a write of 8'hAA @3 (pulse `rst_n` low before E1) → no `ack`. A read @3 afterwards returns the previous value, not 8'hAA.
